// File: rtl/seg_scan_if.sv
// Scan controller bundle: digit word in, digit driver/segment controls out.
// master drives en, lzb_en, digits_in, dp_in and observes the scan outputs;
// slave (the controller) consumes the inputs and drives digit_sel, nibble,
// seg_en, dp_out, cur_digit and frame_done.
interface seg_scan_if #(
    parameter int DIGITS = 3
);
    logic                  en;
    logic                  lzb_en;
    logic [4*DIGITS-1:0]   digits_in;
    logic [DIGITS-1:0]     dp_in;
    logic [DIGITS-1:0]     digit_sel;
    logic [3:0]            nibble;
    logic                  seg_en;
    logic                  dp_out;
    logic [2:0]            cur_digit;
    logic                  frame_done;

    modport master (
        output en,
        output lzb_en,
        output digits_in,
        output dp_in,
        input  digit_sel,
        input  nibble,
        input  seg_en,
        input  dp_out,
        input  cur_digit,
        input  frame_done
    );

    modport slave (
        input  en,
        input  lzb_en,
        input  digits_in,
        input  dp_in,
        output digit_sel,
        output nibble,
        output seg_en,
        output dp_out,
        output cur_digit,
        output frame_done
    );
endinterface

// File: rtl/seg_scan_controller.sv
// Time-multiplexed 7-segment scan scheduler with per-slot blank interval,
// once-per-frame digit snapshot and leading-zero blanking.
// Ports: clk, rst (async, active-high); bus (seg_scan_if.slave):
//   en, lzb_en, digits_in, dp_in in; digit_sel, nibble, seg_en, dp_out,
//   cur_digit, frame_done out. All outputs are registered.
module seg_scan_controller #(
    parameter int DIGITS   = 3,
    parameter int PRESCALE = 65536,
    parameter int BLANK    = 64
) (
    input  logic      clk,
    input  logic      rst,
    seg_scan_if.slave bus
);
    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] CNT_SHOW = CW'(BLANK);
    localparam logic [2:0]    DIG_LAST = 3'(DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BLANK,
        S_SHOW
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2:0]          cur_q, cur_d;
    logic [4*DIGITS-1:0] snap_nib_q, snap_nib_d;
    logic [DIGITS-1:0]   snap_dp_q, snap_dp_d;
    logic                snap_lzb_q, snap_lzb_d;
    logic [DIGITS-1:0]   sel_q, sel_d;
    logic [3:0]          nib_q, nib_d;
    logic                seg_en_q, seg_en_d;
    logic                dp_q, dp_d;
    logic                fd_q, fd_d;

    logic                load;
    logic                zero_hi;
    logic [DIGITS-1:0]   blank_v;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            cur_q      <= '0;
            snap_nib_q <= '0;
            snap_dp_q  <= '0;
            snap_lzb_q <= 1'b0;
            sel_q      <= '0;
            nib_q      <= '0;
            seg_en_q   <= 1'b0;
            dp_q       <= 1'b0;
            fd_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cur_q      <= cur_d;
            snap_nib_q <= snap_nib_d;
            snap_dp_q  <= snap_dp_d;
            snap_lzb_q <= snap_lzb_d;
            sel_q      <= sel_d;
            nib_q      <= nib_d;
            seg_en_q   <= seg_en_d;
            dp_q       <= dp_d;
            fd_q       <= fd_d;
        end
    end

    // Outputs are computed from the next-state values so that every
    // output register lines up with the state it describes.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cur_d      = cur_q;
        snap_nib_d = snap_nib_q;
        snap_dp_d  = snap_dp_q;
        snap_lzb_d = snap_lzb_q;
        fd_d       = 1'b0;
        load       = 1'b0;
        zero_hi    = 1'b1;
        blank_v    = '0;
        sel_d      = '0;
        nib_d      = '0;
        seg_en_d   = 1'b0;
        dp_d       = 1'b0;

        // A falling enable beats a frame wrap: no pulse, straight to idle.
        if (!bus.en) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            cur_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    load    = 1'b1;
                    state_d = S_BLANK;
                    cnt_d   = '0;
                    cur_d   = '0;
                end
                S_BLANK, S_SHOW: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = S_BLANK;
                        if (cur_q == DIG_LAST) begin
                            cur_d = '0;
                            load  = 1'b1;
                            fd_d  = 1'b1;
                        end else begin
                            cur_d = cur_q + 3'd1;
                        end
                    end else begin
                        cnt_d   = cnt_q + CW'(1);
                        state_d = (cnt_d < CNT_SHOW) ? S_BLANK : S_SHOW;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        // The snapshot is taken only at frame start, so a frame never tears.
        if (load) begin
            snap_nib_d = bus.digits_in;
            snap_dp_d  = bus.dp_in;
            snap_lzb_d = bus.lzb_en;
        end

        // Digit i is a leading zero when it and everything above it is 0.
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_hi    = zero_hi & (snap_nib_d[i*4 +: 4] == 4'd0);
            blank_v[i] = snap_lzb_d & zero_hi & (i != 0);
        end

        // Blanked digits keep their slot so brightness stays uniform.
        if (state_d != S_IDLE) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (cur_d == 3'(i)) begin
                    nib_d = snap_nib_d[i*4 +: 4];
                    if (state_d == S_SHOW && !blank_v[i]) begin
                        sel_d[i] = 1'b1;
                        seg_en_d = 1'b1;
                        dp_d     = snap_dp_d[i];
                    end
                end
            end
        end
    end

    assign bus.digit_sel  = sel_q;
    assign bus.nibble     = nib_q;
    assign bus.seg_en     = seg_en_q;
    assign bus.dp_out     = dp_q;
    assign bus.cur_digit  = cur_q;
    assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_controller.sv
// Scoreboard bench for seg_scan_controller: a time-based reference model
// predicts each cycle's outputs; a negedge monitor compares them.
module tb_seg_scan_controller;
    localparam int D     = 3;
    localparam int P     = 8;
    localparam int B     = 2;
    localparam int FRAME = D * P;

    typedef struct packed {
        logic [D-1:0] sel;
        logic [3:0]   nib;
        logic         seg;
        logic         dp;
        logic [2:0]   cur;
        logic         fd;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    seg_scan_if #(.DIGITS(D)) bus ();

    seg_scan_controller #(
        .DIGITS   (D),
        .PRESCALE (P),
        .BLANK    (B)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    bit             run = 1'b0;
    int             t   = 0;
    logic [3:0]     s_nib [D];
    logic [D-1:0]   s_dp;
    logic           s_lzb;

    task automatic take_snapshot();
        for (int k = 0; k < D; k++) s_nib[k] = bus.digits_in[k*4 +: 4];
        s_dp  = bus.dp_in;
        s_lzb = bus.lzb_en;
    endtask

    // Expected outputs from elapsed time since enable and the frame snapshot.
    function automatic exp_t predict(int tt, logic fd);
        exp_t e;
        int   slot;
        int   pos;
        int   hi;
        e    = '0;
        slot = (tt % FRAME) / P;
        pos  = tt % P;
        hi   = 0;
        for (int k = 0; k < D; k++) if (s_nib[k] != 4'd0) hi = k;
        e.cur = 3'(slot);
        e.nib = s_nib[slot];
        e.fd  = fd;
        if (pos >= B && !(s_lzb && slot > hi)) begin
            e.sel = D'(1) << slot;
            e.seg = 1'b1;
            e.dp  = s_dp[slot];
        end
        return e;
    endfunction

    always @(posedge clk) begin
        logic fd;
        fd = 1'b0;
        if (rst || !bus.en) begin
            run = 1'b0;
            sb.push_back('0);
        end else begin
            if (!run) begin
                run = 1'b1;
                t   = 0;
                take_snapshot();
            end else begin
                t = t + 1;
                if (t % FRAME == 0) begin
                    take_snapshot();
                    fd = 1'b1;
                end
            end
            sb.push_back(predict(t, fd));
        end
    end

    always @(negedge clk) begin
        exp_t e;
        exp_t a;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            a = {bus.digit_sel, bus.nibble, bus.seg_en, bus.dp_out,
                 bus.cur_digit, bus.frame_done};
            tests++;
            if (a !== e) begin
                fails++;
                $display("FAIL scan @%0t got sel=%b nib=%h seg=%b dp=%b cur=%0d fd=%b want sel=%b nib=%h seg=%b dp=%b cur=%0d fd=%b",
                         $time, a.sel, a.nib, a.seg, a.dp, a.cur, a.fd,
                         e.sel, e.nib, e.seg, e.dp, e.cur, e.fd);
            end
        end
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic check_zero(string name);
        exp_t a;
        a = {bus.digit_sel, bus.nibble, bus.seg_en, bus.dp_out,
             bus.cur_digit, bus.frame_done};
        tests++;
        if (a !== '0) begin
            fails++;
            $display("FAIL %s got %b want all zero", name, a);
        end
    endtask

    logic [4*D-1:0] rnd_nib;

    initial begin
        bus.en        = 1'b0;
        bus.lzb_en    = 1'b0;
        bus.digits_in = '0;
        bus.dp_in     = '0;
        #1 rst = 1'b1;
        #2 check_zero("reset_init");
        tick(3);
        rst = 1'b0;

        bus.digits_in = 12'h321;
        bus.dp_in     = 3'b010;
        bus.en        = 1'b1;
        tick(2 * FRAME);

        tick(P + 3);
        bus.digits_in = 12'h987;
        tick(2 * FRAME);

        tick(P + 5);
        bus.en = 1'b0;
        tick(3);
        bus.en = 1'b1;
        tick(FRAME + 2);

        bus.digits_in = 12'h005;
        bus.lzb_en    = 1'b1;
        tick(2 * FRAME);
        bus.digits_in = 12'h000;
        tick(2 * FRAME);
        bus.digits_in = 12'h005;
        bus.lzb_en    = 1'b0;
        tick(2 * FRAME);

        bus.en = 1'b0;
        tick(2);
        bus.en        = 1'b1;
        bus.digits_in = 12'h321;
        tick(FRAME);
        bus.en = 1'b0;
        tick(3);

        bus.en = 1'b1;
        tick(6);
        #1;
        rst = 1'b1;
        sb.delete();
        #1 check_zero("reset_async");
        @(posedge clk);
        #2 rst = 1'b0;
        tick(FRAME + 4);

        for (int i = 0; i < 600; i++) begin
            tick(1);
            if ($urandom % 5 == 0) begin
                for (int k = 0; k < D; k++)
                    rnd_nib[k*4 +: 4] = ($urandom % 2 == 0) ? 4'd0 : 4'($urandom);
                bus.digits_in = rnd_nib;
                bus.dp_in     = D'($urandom);
                bus.lzb_en    = 1'($urandom);
            end
            if ($urandom % 60 == 0) bus.en = ~bus.en;
        end
        bus.en = 1'b1;
        tick(FRAME);

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seg_scan_controller.md
Name: seg_scan_controller

Overview:
- Time-multiplexed scan scheduler that shares one 7-segment decoder and one segment bus between DIGITS common-cathode/anode digit drivers.
- Sequences digit selection with a per-slot anti-ghosting blank interval, snapshots the BCD/hex digit word once per frame to prevent tearing, and applies optional leading-zero blanking.
- Sits between the cascaded decade up/down counters (digit nibbles in) and the seg7 decoder plus digit-select pins (out). It replaces the free-running decade-counter scan.

Parameters:
- DIGITS, 3, number of multiplexed digits (1..8).
- PRESCALE, 65536, clk cycles per digit slot (blank + show); must be > BLANK.
- BLANK, 64, clk cycles at slot start with every digit deselected and seg_en=0; must be >= 1.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; asynchronous, active-high.
- en  input  1  scan enable; low forces IDLE.
- lzb_en  input  1  leading-zero blanking enable; sampled at frame snapshot.
- digits_in  input  4*DIGITS  digit nibbles; [3:0] = digit 0 (least significant).
- dp_in  input  DIGITS  decimal-point request per digit.
- digit_sel  output  DIGITS  one-hot active-high digit driver enables.
- nibble  output  4  current digit value to the seg7 decoder.
- seg_en  output  1  segment bus enable (0 = all segments off).
- dp_out  output  1  decimal point for the current digit, gated by seg_en.
- cur_digit  output  3  index of the current slot.
- frame_done  output  1  one-cycle pulse at frame wrap.

Behaviour:
- Reset (async, immediate, no clock needed): state=IDLE, slot counter=0, cur_digit=0, snapshot=0, digit_sel=0, nibble=0, seg_en=0, dp_out=0, frame_done=0.
- States: IDLE, BLANK, SHOW. All outputs are registered.
- IDLE: all outputs 0. If en=1, the next edge does the following:
  - latches digits_in, dp_in and lzb_en into the snapshot;
  - sets cur_digit=0 and counter=0;
  - enters BLANK.
- BLANK: lasts exactly BLANK cycles.
  - digit_sel=0, seg_en=0, dp_out=0.
  - nibble = snapshot[cur_digit] (pre-settles the decoder).
  - Then enters SHOW.
- SHOW: lasts exactly PRESCALE-BLANK cycles.
  - nibble = snapshot[cur_digit].
  - digit_sel = one-hot(cur_digit), seg_en=1, dp_out = snapshot dp[cur_digit], unless the digit is LZB-blanked.
  - LZB-blanked digit: digit_sel=0, seg_en=0, dp_out=0 for the whole slot.
  - Slot timing is unchanged by blanking; brightness stays uniform.
- Slot end:
  - If cur_digit < DIGITS-1: cur_digit+1, enter BLANK.
  - If cur_digit = DIGITS-1: cur_digit=0, re-snapshot on the same edge, frame_done=1 for exactly that one following cycle (the first BLANK cycle of the new frame), enter BLANK.
- Frame length = DIGITS*PRESCALE cycles.
- Leading-zero blanking (snapshot lzb_en=1):
  - Digit i is blanked iff every snapshot nibble at index >= i is 0 and i != 0.
  - Digit 0 is never blanked.
  - dp of a blanked digit is suppressed.
- Tearing: digits_in/dp_in/lzb_en changes mid-frame have no output effect until the next frame_done.
- en deasserted in any state: the next edge enters IDLE with all outputs 0. Re-enable restarts at digit 0 with a fresh snapshot.
- Counter width = clog2(PRESCALE). No overflow is possible because the counter is compared and cleared at PRESCALE-1.
- Simultaneous en fall and frame wrap: en wins, so the next state is IDLE and there is no frame_done pulse.
- digit_sel is never multi-hot. At most one bit is set, and only while seg_en=1.

Test Plan:
- Bench parameters: DIGITS=3, PRESCALE=8, BLANK=2.
- Async reset: assert rst mid-SHOW between clock edges -> all outputs 0 immediately. Release with en=1 -> first BLANK begins after the next edge.
- Basic scan: en=1, digits_in=12'h321, dp_in=3'b010, lzb_en=0, with the frame starting on entry from IDLE:
  - cycles 1-2 blank; cycles 3-8 digit_sel=001, nibble=1, dp_out=0;
  - cycles 9-10 blank; cycles 11-16 digit_sel=010, nibble=2, dp_out=1;
  - cycles 17-18 blank; cycles 19-24 digit_sel=100, nibble=3;
  - frame_done pulses once every 24 cycles.
- LZB: digits_in=12'h005, lzb_en=1 -> only slot 0 shows 001/5; slots 1-2 keep digit_sel=000 and seg_en=0. digits_in=12'h000 -> digit 0 shows 0. With lzb_en=0, 12'h005 shows all three digits.
- Anti-tear: change digits_in from 12'h321 to 12'h987 during slot 1 -> slots 1 and 2 still show 2 and 3; 7/8/9 appear only after frame_done.
- en drop: deassert en in the 4th SHOW cycle of slot 1 -> next cycle all outputs 0, state IDLE. Re-assert -> restart at digit 0 with blank first.
- Wrap race: deassert en on the last SHOW cycle of slot 2 -> no frame_done pulse, outputs go to 0.
